pipe_stage_register: RTL
========================

PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 Parameter CTRL_W, 9, width of control bundle; its bits are zeroed on bubble/flush.
REQ-002 Parameter DATA_W, 128, width of payload bundle (register data, immediate, PC, rs/rd, funct); held, not zeroed, on flush.
REQ-003 Parameter CNT_W, 16, width of stall-cycle counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream stage holds a valid instruction.
REQ-007 in_ready  output  1  stage accepts input this cycle.
REQ-008 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 in_data  input  DATA_W  upstream payload bundle.
REQ-010 flush  input  1  squash all held and incoming entries (branch taken).
REQ-011 out_valid  output  1  output entry is valid.
REQ-012 out_ready  input  1  downstream accepts output; low = stall.
REQ-013 out_ctrl  output  CTRL_W  control bundle; all-zero whenever out_valid=0.
REQ-014 out_data  output  DATA_W  payload bundle.
REQ-015 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Transfer in occurs when in_valid and in_ready are high at a clk edge; transfer out occurs when out_valid and out_ready are high at a clk edge.
REQ-017 Latency is one cycle: an accepted entry appears on outputs the cycle after acceptance.
REQ-018 The stage holds out_ctrl/out_data/out_valid unchanged while out_valid=1 and out_ready=0.
REQ-019 When in_valid=0 and the output slot frees, out_valid=0 and out_ctrl=0 (bubble) at the next edge.
REQ-020 On flush=1 at an edge: every held entry is invalidated, out_ctrl=0, the incoming entry is dropped, and out_data keeps the in_data value for forwarding visibility.
REQ-021 Flush has priority over the handshake; in_valid coincident with flush is never delivered.
REQ-022 Entries leave in the same order they were accepted; no entry is duplicated or lost except by flush.
REQ-023 stall_cnt increments by 1 per stall cycle, saturates at 2^CNT_W-1, and is not cleared by flush.

Reset
REQ-024 reset=1 at an edge: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, and all skid entries are emptied.
REQ-025 reset overrides flush and the handshake; in_ready is 1 in the cycle after reset is released.

Configuration
REQ-026 With macro PIPE_SKID_EN defined: a 2-entry skid buffer is used; in_ready is driven only by flops (high when fewer than 2 entries are held); an entry accepted while out_ready=0 is stored in the skid slot.
REQ-027 Without PIPE_SKID_EN: a single entry is held; in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-028 Both builds produce an identical out_* sequence for identical input streams.

Structure
REQ-029 Package pipe_pkg holds the default CTRL_W/DATA_W, control-bit index constants (REGWRITE, MEMTOREG, MEMREAD, MEMWRITE, BRANCH, ALUSRC, ALUOP[1:0]), and the payload field offsets.
REQ-030 Sub-module pipe_skid_buf implements the 2-entry storage and full/empty flags; it is instantiated only under PIPE_SKID_EN.

Verification
REQ-031 Stream: in_valid=1 for 4 cycles with in_data=1..4 and out_ready=1 -> out_data=1..4 on consecutive cycles, each one cycle after input.
REQ-032 Stall: out_ready=0 for 3 cycles while in_ctrl=0x1FF and in_data=0xA5 are held -> outputs are frozen and stall_cnt=3; with PIPE_SKID_EN, in_ready=0 after 2 entries are held.
REQ-033 Flush: 2 entries held and flush=1 with in_valid=1 -> next cycle out_valid=0 and out_ctrl=0, no held entry is delivered, and in_ready=1.
REQ-034 Bubble: in_valid=0 with out_ready=1 -> out_valid=0 and out_ctrl=0x000 next cycle.
REQ-035 Reset mid-stall: with stall_cnt=5 and 1 entry held, reset=1 for 1 cycle -> all outputs 0 and stall_cnt=0.
REQ-036 Saturation: CNT_W=4 and 20 stall cycles -> stall_cnt stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, control-bit indices and payload layout for the pipeline stage register.
// No logic; constants and types only.
// Not applicable: holds no state, so it applies no backpressure.
package pipe_pkg;

   // Default bundle widths
   localparam int PIPE_CTRL_W = 9;
   localparam int PIPE_DATA_W = 128;

   // Control bundle bit positions. These bits are squashed to zero on bubble/flush.
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_BRANCH   = 4;
   localparam int CTRL_ALUSRC   = 5;
   localparam int CTRL_ALUOP_LO = 6;
   localparam int CTRL_ALUOP_HI = 7;
   localparam int CTRL_SPARE    = 8;

   // Payload field offsets (LSB position) and widths within the 128-bit bundle
   localparam int PAY_RDATA_OFS = 0;
   localparam int PAY_RDATA_W   = 32;
   localparam int PAY_IMM_OFS   = 32;
   localparam int PAY_IMM_W     = 32;
   localparam int PAY_PC_OFS    = 64;
   localparam int PAY_PC_W      = 32;
   localparam int PAY_RS1_OFS   = 96;
   localparam int PAY_RS2_OFS   = 101;
   localparam int PAY_RD_OFS    = 106;
   localparam int PAY_REG_W     = 5;
   localparam int PAY_FUNCT_OFS = 111;
   localparam int PAY_FUNCT_W   = 10;

   // Same layout as a packed struct, for consumers that prefer named fields
   typedef struct packed {
      logic [6:0]  spare;
      logic [9:0]  funct;
      logic [4:0]  rd;
      logic [4:0]  rs2;
      logic [4:0]  rs1;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rdata;
   } payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry stage storage: a head slot that drives the stage outputs plus one skid slot behind it.
// Latency: an entry pushed into an empty buffer is visible at the head one cycle later.
// Backpressure: the skid slot absorbs one entry while pop_rdy is low; full is a pure flop output.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [CTRL_W-1:0] push_ctrl,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_rdy,
   output logic [CTRL_W-1:0] head_ctrl,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty
);

   logic              head_vld;
   logic              skid_vld;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   // The skid slot is only ever occupied behind a valid head, so skid_vld alone means two entries held
   assign full  = skid_vld;
   assign empty = !head_vld;

   // Head refills from the skid slot first to keep order; a stalled head diverts the push into the skid slot
   always_ff @(posedge clk) begin
      if (reset) begin
         head_vld  <= 1'b0;
         head_ctrl <= '0;
         head_data <= '0;
         skid_vld  <= 1'b0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         // Squash both slots; head_data shows the incoming payload for forwarding visibility
         head_vld  <= 1'b0;
         head_ctrl <= '0;
         head_data <= push_data;
         skid_vld  <= 1'b0;
      end else if (!head_vld || pop_rdy) begin
         if (skid_vld) begin
            head_vld  <= 1'b1;
            head_ctrl <= skid_ctrl;
            head_data <= skid_data;
            skid_vld  <= 1'b0;
         end else if (push) begin
            head_vld  <= 1'b1;
            head_ctrl <= push_ctrl;
            head_data <= push_data;
         end else begin
            head_vld  <= 1'b0;
            head_ctrl <= '0;
         end
      end else if (push) begin
         skid_vld  <= 1'b1;
         skid_ctrl <= push_ctrl;
         skid_data <= push_data;
      end
   end

endmodule

// File: rtl/pipe_stage_register.sv
// Pipeline stage register with valid/ready handshake, flush squash and a saturating stall counter.
// Latency: one cycle from input acceptance to output. Optional 2-entry skid storage under PIPE_SKID_EN.
// Backpressure: out_ready low freezes the outputs; in_ready = !out_valid || out_ready, or flop-only with PIPE_SKID_EN.
module pipe_stage_register
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_SKID_EN

   logic skid_full;
   logic skid_empty;

   // in_ready comes straight from the skid-full flop, breaking the combinational path from out_ready
   assign in_ready  = !skid_full;
   assign out_valid = !skid_empty;

   pipe_skid_buf #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (in_valid && in_ready),
      .push_ctrl (in_ctrl),
      .push_data (in_data),
      .pop_rdy   (out_ready),
      .head_ctrl (out_ctrl),
      .head_data (out_data),
      .full      (skid_full),
      .empty     (skid_empty)
   );

`else

   // Single slot: accept whenever the slot is empty or is being drained this cycle
   assign in_ready = !out_valid || out_ready;

   // Load on accept, insert a bubble when the slot frees with nothing incoming, squash on flush
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= in_data;
      end else if (in_ready) begin
         if (in_valid) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
         end else begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
         end
      end
   end

`endif

   // Count cycles where a valid output is held back by downstream; saturates and survives flush
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
